uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 16x-oversampled UART receiver. Consumes the tick_16x strobe from the baud-rate generator and converts the serial line to bytes.
- Outputs bytes on a valid/ready interface and flags framing and overrun errors.
- Sits on the RX side of the UART, mirroring the TX path that shares the same baud-rate generator.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLING, 16, ticks per bit; must be even and >= 4.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock domain; reset is synchronous and active-high
- rx_en  input  1  receiver enable; low forces IDLE
- tick_16x  input  1  one-clk oversample strobe from the baud-rate generator
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received word, stable while rx_valid=1
- rx_valid  output  1  word available; held until accepted
- rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- overrun  output  1  one-clk pulse: frame completed while rx_valid still 1
- parity_err  output  1  one-clk pulse: parity mismatch (tied 0 without the macro)
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (rst=1 at posedge clk) values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0. State=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: rx passes through a 2-flop synchronizer (rx_s) every clk. All decisions use rx_s.
- Timing: state and counter advance only on clk cycles with tick_16x=1. The sample counter width is $clog2(OVERSAMPLING).
- IDLE: on tick with rx_s=0, go to START with cnt=0.
- START: on each tick, cnt++. At cnt==OVERSAMPLING/2-1 (mid start bit):
  - rx_s=0: go to DATA, cnt=0, bit_idx=0.
  - rx_s=1: glitch; return to IDLE with no flags.
- DATA: on each tick, cnt++. At cnt==OVERSAMPLING-1 (mid bit):
  - Shift rx_s into the shift-register MSB (LSB-first assembly), cnt=0, bit_idx++.
  - After DATA_BITS samples, go to PARITY (macro defined) or STOP.
- STOP: sample at cnt==OVERSAMPLING-1.
  - rx_s=1: frame good, deliver, go to IDLE.
  - rx_s=0: frame_err pulse, word discarded, go to BREAK.
- BREAK: stay until a tick with rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Deliver, when rx_valid=0: rx_data<=shift register, rx_valid<=1 on the clk after the stop-sample tick (latency 1 clk).
- Deliver, when rx_valid=1 and not accepted that same cycle: overrun pulse, old rx_data kept, new word dropped.
- Simultaneous accept and deliver in the same cycle: new word loads, rx_valid stays 1, no overrun.
- Handshake: rx_valid deasserts the clk after rx_valid & rx_ready.
- Error pulses are exactly 1 clk wide, and only one error per frame. Precedence: frame_err over parity_err over overrun. A frame with parity_err is not delivered.
- rx_en=0: state to IDLE and counters cleared on the next clk. rx_valid and rx_data are unaffected.
- rst mid-frame: all state returns to reset values on the next clk and the partial frame is discarded.
- tick_16x absent: the FSM holds. Stall duration has no limit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA. One bit is sampled at mid-bit and compared against the XOR of the data bits (inverted if PARITY_ODD=1). On mismatch, the frame runs to STOP; if stop=1, a parity_err pulse fires and the word is dropped.
- Undefined: no PARITY state, frame is start+DATA_BITS+stop, parity_err is constant 0, PARITY_ODD is ignored.

Test Plan:
- Common setup: tick_16x every 27 clk (50 MHz, 115200), rx_ready=1.
- Good frame: send 0xA5 (8N1) -> rx_valid high 1 clk after stop mid-sample, rx_data=0xA5, no error flags.
- Glitch: 3-tick low pulse on idle rx -> FSM returns to IDLE at the mid-start check, rx_valid stays 0, busy drops within 8 ticks.
- Framing error: 0x3C with stop=0, then line held low for 40 bit-times, then high -> single frame_err pulse, no rx_valid, no retrigger until the line goes high, then 0x55 received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, one overrun pulse at the second stop; rx_ready=1 -> rx_valid drops, rx_data=0x11.
- Reset mid-frame: assert rst during data bit 4 of 0xFF, then send 0x81 -> outputs reset next clk, only 0x81 delivered.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0): 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with valid/ready byte output.
// Optional parity bit is compiled in by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LBIT = BW'(DATA_BITS - 1);

  if (OVERSAMPLING < 4 || (OVERSAMPLING % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q, ovr_q;
  logic                 deliver, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (tick_16x) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            sh_d  = {rx_s_q, sh_q[DATA_BITS-1:1]};
            idx_d = idx_q + BW'(1);
            if (idx_q == LBIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            pbad_d  = rx_s_q ^ (^sh_q) ^ 1'(PARITY_ODD);
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end else begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              if (pbad_q) perr_d = 1'b1;
              else        deliver = 1'b1;
`else
              deliver = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // a held-low line must go high before a new start is accepted
        BRK: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      ovr_q  <= 1'b0;
      if (deliver) begin
        if (!valid_q || rx_ready) begin
          data_q  <= sh_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level model.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b0;
  logic          tick_16x = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;
  logic          busy;

  int div = 27;
  int tick_cnt = 0;
  int errors = 0;
  int checks = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  logic v_prev = 1'b0;
  logic [DB-1:0] got[$];

  uart_rx #(
    .DATA_BITS(DB),
    .OVERSAMPLING(OS),
    .PARITY_ODD(int'(PODD))
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .tick_16x(tick_16x),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (tick_cnt >= div - 1) begin
      tick_cnt = 0;
      tick_16x = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      tick_16x = 1'b0;
    end
  end

  // pulse counters count high cycles, so a wide pulse shows as >1
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rx_valid === 1'b1 && v_prev !== 1'b1) n_rise = n_rise + 1;
      if (rx_valid === 1'b1 && rx_ready) got.push_back(rx_data);
      if (frame_err === 1'b1) n_ferr = n_ferr + 1;
      if (overrun === 1'b1) n_ovr = n_ovr + 1;
      if (parity_err === 1'b1) n_perr = n_perr + 1;
    end
    v_prev = rx_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) step();
  endtask

  function automatic int bit_clk();
    return OS * div;
  endfunction

  function automatic int ev_sum();
    return n_rise + n_ferr + n_ovr + n_perr;
  endfunction

  function automatic int err_sum();
    return n_ferr + n_ovr + n_perr;
  endfunction

  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ PODD;
  endfunction

  function automatic bit frame_ok(input logic [DB-1:0] d,
                                  input logic par, input logic stop);
    return stop && (!PAR_EN || par == good_par(d));
  endfunction

  function automatic logic [DB-1:0] last_got();
    if (got.size() == 0) return 'x;
    return got[got.size()-1];
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clk(bit_clk());
  endtask

  // ev_off: clocks into the stop bit until the first output event
  task automatic send_frame(input logic [DB-1:0] d, input logic par,
                            input logic stop, output int ev_off);
    logic [DB+2:0] fr;
    int nb;
    int base;
    fr = {stop, par, d, 1'b0};
    if (!PAR_EN) fr[DB+1] = stop;
    nb = PAR_EN ? DB + 2 : DB + 1;
    for (int i = 0; i < nb; i++) drive_bit(fr[i]);
    rx = stop;
    ev_off = -1;
    base = ev_sum();
    for (int k = 0; k < bit_clk(); k++) begin
      step();
      if (ev_off < 0 && ev_sum() != base) ev_off = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rx_en = 1'b1;
    rx_ready = 1'b1;
    wait_clk(4);
    checks++;
    if (rx_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h want 0", rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b want 0", rx_valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr: got %0b want 0", frame_err);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovr: got %0b want 0", overrun);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr: got %0b want 0", parity_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_good_frame();
    int ev, r0, a0, e0;
    div = 27;
    drive_bit(1'b1);
    r0 = n_rise;
    a0 = got.size();
    e0 = err_sum();
    send_frame(8'hA5, good_par(8'hA5), 1'b1, ev);
    checks++;
    if (ev < bit_clk() / 4) begin
      errors++;
      $display("FAIL good_timing: event %0d clk into stop, want >= %0d",
               ev, bit_clk() / 4);
    end
    checks++;
    if (n_rise - r0 != 1) begin
      errors++;
      $display("FAIL good_rise: got %0d valid rises want 1", n_rise - r0);
    end
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'hA5) begin
      errors++;
      $display("FAIL good_data: got %0h (n=%0d) want a5",
               last_got(), got.size() - a0);
    end
    checks++;
    if (err_sum() != e0) begin
      errors++;
      $display("FAIL good_flags: got %0d error pulses want 0", err_sum() - e0);
    end
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_idle: got valid=%0b busy=%0b want 0/0",
               rx_valid, busy);
    end
    drive_bit(1'b1);
  endtask

  task automatic test_glitch();
    int r0, e0;
    bit seen;
    div = 27;
    r0 = n_rise;
    e0 = err_sum();
    seen = 1'b0;
    rx = 1'b0;
    for (int k = 0; k < 3 * div; k++) begin
      step();
      if (busy === 1'b1) seen = 1'b1;
    end
    rx = 1'b1;
    wait_clk(8 * div + 4);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy never rose, got %0b want 1", seen);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy got %0b want 0", busy);
    end
    checks++;
    if (n_rise != r0 || err_sum() != e0) begin
      errors++;
      $display("FAIL glitch_quiet: got rises=%0d errs=%0d want 0/0",
               n_rise - r0, err_sum() - e0);
    end
    drive_bit(1'b1);
  endtask

  task automatic test_frame_err();
    int ev, r0, a0, f0;
    div = 27;
    r0 = n_rise;
    a0 = got.size();
    f0 = n_ferr;
    send_frame(8'h3C, good_par(8'h3C), 1'b0, ev);
    checks++;
    if (ev < bit_clk() / 4) begin
      errors++;
      $display("FAIL ferr_timing: event %0d clk into stop, want >= %0d",
               ev, bit_clk() / 4);
    end
    repeat (40) drive_bit(1'b0);
    checks++;
    if (n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d cycles want 1", n_ferr - f0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_break: busy got %0b want 1", busy);
    end
    checks++;
    if (n_rise != r0 || got.size() != a0) begin
      errors++;
      $display("FAIL ferr_nodata: got %0d words want 0", got.size() - a0);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_release: busy got %0b want 0", busy);
    end
    send_frame(8'h55, good_par(8'h55), 1'b1, ev);
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'h55) begin
      errors++;
      $display("FAIL ferr_next: got %0h (n=%0d) want 55",
               last_got(), got.size() - a0);
    end
    checks++;
    if (n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL ferr_once: got %0d cycles want 1", n_ferr - f0);
    end
    drive_bit(1'b1);
  endtask

  task automatic test_overrun();
    int ev, r0, a0, o0;
    div = 27;
    r0 = n_rise;
    a0 = got.size();
    o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, good_par(8'h11), 1'b1, ev);
    drive_bit(1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++;
      $display("FAIL ovr_first: got valid=%0b data=%0h want 1/11",
               rx_valid, rx_data);
    end
    send_frame(8'h22, good_par(8'h22), 1'b1, ev);
    checks++;
    if (ev < bit_clk() / 4) begin
      errors++;
      $display("FAIL ovr_timing: event %0d clk into stop, want >= %0d",
               ev, bit_clk() / 4);
    end
    checks++;
    if (n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL ovr_pulse: got %0d cycles want 1", n_ovr - o0);
    end
    checks++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hold: got valid=%0b data=%0h want 1/11",
               rx_valid, rx_data);
    end
    checks++;
    if (n_rise - r0 != 1 || got.size() != a0) begin
      errors++;
      $display("FAIL ovr_count: got rises=%0d words=%0d want 1/0",
               n_rise - r0, got.size() - a0);
    end
    rx_ready = 1'b1;
    step();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_accept: valid got %0b want 0", rx_valid);
    end
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'h11) begin
      errors++;
      $display("FAIL ovr_word: got %0h (n=%0d) want 11",
               last_got(), got.size() - a0);
    end
    drive_bit(1'b1);
  endtask

  task automatic test_reset_mid();
    int ev, a0;
    div = 27;
    a0 = got.size();
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    wait_clk(bit_clk() / 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got %0b want 1", busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: got busy=%0b valid=%0b data=%0h want 0",
               busy, rx_valid, rx_data);
    end
    rst = 1'b0;
    wait_clk(bit_clk() / 2);
    repeat (4) drive_bit(1'b1);
    checks++;
    if (busy !== 1'b0 || got.size() != a0) begin
      errors++;
      $display("FAIL rstmid_drop: got busy=%0b words=%0d want 0/0",
               busy, got.size() - a0);
    end
    send_frame(8'h81, good_par(8'h81), 1'b1, ev);
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_next: got %0h (n=%0d) want 81",
               last_got(), got.size() - a0);
    end
    drive_bit(1'b1);
  endtask

  task automatic test_rx_en();
    int ev, a0, e0;
    div = 8;
    a0 = got.size();
    e0 = err_sum();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_clk(bit_clk() / 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL en_busy: got %0b want 1", busy);
    end
    rx_en = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_idle: got %0b want 0", busy);
    end
    wait_clk(3);
    rx_en = 1'b1;
    repeat (8) drive_bit(1'b1);
    checks++;
    if (got.size() != a0 || err_sum() != e0) begin
      errors++;
      $display("FAIL en_drop: got words=%0d errs=%0d want 0/0",
               got.size() - a0, err_sum() - e0);
    end
    send_frame(8'h5A, good_par(8'h5A), 1'b1, ev);
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'h5A) begin
      errors++;
      $display("FAIL en_next: got %0h (n=%0d) want 5a",
               last_got(), got.size() - a0);
    end
    drive_bit(1'b1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int ev, a0, p0;
    div = 27;
    a0 = got.size();
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, ev);
    drive_bit(1'b1);
    checks++;
    if (got.size() != a0 + 1 || last_got() !== 8'h07 || n_perr != p0) begin
      errors++;
      $display("FAIL par_good: got %0h (n=%0d perr=%0d) want 07",
               last_got(), got.size() - a0, n_perr - p0);
    end
    send_frame(8'h07, 1'b0, 1'b1, ev);
    checks++;
    if (ev < bit_clk() / 4) begin
      errors++;
      $display("FAIL par_timing: event %0d clk into stop, want >= %0d",
               ev, bit_clk() / 4);
    end
    checks++;
    if (n_perr - p0 != 1 || got.size() != a0 + 1) begin
      errors++;
      $display("FAIL par_bad: got perr=%0d words=%0d want 1/0",
               n_perr - p0, got.size() - a0 - 1);
    end
    drive_bit(1'b1);
  endtask
`endif

  task automatic test_random();
    int ev, a0, f0, p0, o0;
    logic [DB-1:0] d;
    logic par, stop;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      div = $urandom_range(1, 4);
      d = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par = good_par(d) ^ ($urandom_range(0, 3) == 0);
      ok = frame_ok(d, par, stop);
      a0 = got.size();
      f0 = n_ferr;
      p0 = n_perr;
      o0 = n_ovr;
      send_frame(d, par, stop, ev);
      checks++;
      if (ev < bit_clk() / 4) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: event %0d clk into stop, want >= %0d",
                 n, ev, bit_clk() / 4);
      end
      checks++;
      if (got.size() - a0 != int'(ok)) begin
        errors++;
        $display("FAIL rnd_count[%0d]: got %0d words want %0d",
                 n, got.size() - a0, ok);
      end
      checks++;
      if (ok && last_got() !== d) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got %0h want %0h", n, last_got(), d);
      end
      checks++;
      if (n_ferr - f0 != int'(!stop) || n_ovr != o0 ||
          n_perr - p0 != int'(stop && !ok)) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got f=%0d p=%0d o=%0d want f=%0d p=%0d o=0",
                 n, n_ferr - f0, n_perr - p0, n_ovr - o0,
                 !stop, stop && !ok);
      end
      repeat ($urandom_range(1, 3)) drive_bit(1'b1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_idle: busy got %0b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_rx_en();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
